// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, port
// indices, and the address range check.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned PORT_CORE = 0;
  localparam int unsigned PORT_DBG  = 1;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned STAT_W    = 32;

  // An address is in range when no bit at or above addr_len is set.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned addr_len);
    return (addr >> addr_len) == '0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side access port: request, write enable, address and write data
// from the requester; grant and read return back to it.
interface mem_arbiter_if #(
  parameter int unsigned p_WORD_LEN = 16
);
  import mem_arb_pkg::*;

  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [p_WORD_LEN-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [p_WORD_LEN-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/mem_arb_rsp.sv
// One-stage read-return tracker: remembers which port owns the read issued
// last cycle and whether its address was in range, then routes the memory
// read data to that port's rvalid/rdata.
module mem_arb_rsp
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_fire,
  input  logic                  i_rd_owner,
  input  logic                  i_rd_in_range,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
  output logic                  o_c_rvalid,
  output logic [p_WORD_LEN-1:0] o_c_rdata,
  output logic                  o_d_rvalid,
  output logic [p_WORD_LEN-1:0] o_d_rdata
);

  logic                  r_c_rvalid;
  logic                  r_d_rvalid;
  logic                  r_in_range;
  logic                  w_c_rvalid;
  logic                  w_d_rvalid;
  logic [p_WORD_LEN-1:0] w_rd_data;

  // Capture owner and range of the read granted this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_in_range <= 1'b0;
    end else begin
      r_c_rvalid <= i_rd_fire && (i_rd_owner == 1'(PORT_CORE));
      r_d_rvalid <= i_rd_fire && (i_rd_owner == 1'(PORT_DBG));
      r_in_range <= i_rd_in_range;
    end
  end

  // A read launched just before reset must not surface while reset is high.
  assign w_c_rvalid = r_c_rvalid && !i_rst;
  assign w_d_rvalid = r_d_rvalid && !i_rst;
  assign w_rd_data  = r_in_range ? i_mem_rd_data : '0;

  assign o_c_rvalid = w_c_rvalid;
  assign o_d_rvalid = w_d_rvalid;
  assign o_c_rdata  = w_c_rvalid ? w_rd_data : '0;
  assign o_d_rdata  = w_d_rvalid ? w_rd_data : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: core port and debug/loader port share one
// single-port memory. Core wins conflicts until the debug port has waited
// p_STARVE_LIMIT core grants; debug can lock the memory for a burst.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_WORD_LEN     = 16,
  parameter int unsigned p_ADDR_LEN     = 10,
  parameter int unsigned p_STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_arbiter_if.slave          c_port,
  mem_arbiter_if.slave          d_port,
  input  logic                  i_d_lock,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     o_stat_conflicts,
  output logic [STAT_W-1:0]     o_stat_lock_cycles
`endif
);

  localparam int unsigned     CNT_W      = $clog2(p_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(p_STARVE_LIMIT);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_starve;
  logic [CNT_W-1:0]      w_starve_nxt;
  logic                  w_lock_own;
  logic                  w_c_gnt;
  logic                  w_d_gnt;
  logic                  w_grant;
  logic                  w_we;
  logic                  w_in_range;
  logic [ADDR_W-1:0]     w_addr;
  logic [p_WORD_LEN-1:0] w_wdata;
  logic                  w_c_rvalid;
  logic                  w_d_rvalid;
  logic [p_WORD_LEN-1:0] w_c_rdata;
  logic [p_WORD_LEN-1:0] w_d_rdata;

  // Debug owns the memory only while locked and still holding i_d_lock.
  assign w_lock_own = (r_state == ST_LOCK) && i_d_lock;

  // State and starvation counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_ARB;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Grant decision and next state.
  always_comb begin
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_state_nxt = r_state;
    if (!i_rst) begin
      if (w_lock_own) begin
        w_d_gnt = d_port.req;
      end else if (c_port.req && d_port.req) begin
        w_d_gnt = (r_starve == STARVE_MAX);
        w_c_gnt = !w_d_gnt;
      end else begin
        w_c_gnt = c_port.req;
        w_d_gnt = d_port.req;
      end
    end
    case (r_state)
      ST_ARB:  if (w_d_gnt && i_d_lock) w_state_nxt = ST_LOCK;
      ST_LOCK: if (!i_d_lock) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // Count core grants taken while debug waits; clear once debug is served or idle.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_d_gnt || !d_port.req) begin
      w_starve_nxt = '0;
    end else if (w_c_gnt && (r_starve != STARVE_MAX)) begin
      w_starve_nxt = r_starve + CNT_W'(1);
    end
  end

  // Steer the granted port onto the memory; out-of-range writes are dropped.
  assign w_grant       = w_c_gnt || w_d_gnt;
  assign w_addr        = w_d_gnt ? d_port.addr  : c_port.addr;
  assign w_we          = w_d_gnt ? d_port.we    : c_port.we;
  assign w_wdata       = w_d_gnt ? d_port.wdata : c_port.wdata;
  assign w_in_range    = addr_in_range(w_addr, p_ADDR_LEN);
  assign o_mem_addr    = w_addr[p_ADDR_LEN-1:0];
  assign o_mem_wr_en   = w_grant && w_we && w_in_range;
  assign o_mem_wr_data = w_wdata;

  assign c_port.gnt    = w_c_gnt;
  assign d_port.gnt    = w_d_gnt;

  mem_arb_rsp #(
    .p_WORD_LEN(p_WORD_LEN)
  ) u_rsp (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_rd_fire     (w_grant && !w_we),
    .i_rd_owner    (w_d_gnt ? 1'(PORT_DBG) : 1'(PORT_CORE)),
    .i_rd_in_range (w_in_range),
    .i_mem_rd_data (i_mem_rd_data),
    .o_c_rvalid    (w_c_rvalid),
    .o_c_rdata     (w_c_rdata),
    .o_d_rvalid    (w_d_rvalid),
    .o_d_rdata     (w_d_rdata)
  );

  assign c_port.rvalid = w_c_rvalid;
  assign c_port.rdata  = w_c_rdata;
  assign d_port.rvalid = w_d_rvalid;
  assign d_port.rdata  = w_d_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_conflicts;
  logic [STAT_W-1:0] r_stat_lock_cycles;

  // Saturating counts of shared-mode conflicts and locked-ownership cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_conflicts   <= '0;
      r_stat_lock_cycles <= '0;
    end else begin
      if (!w_lock_own && c_port.req && d_port.req && (r_stat_conflicts != '1))
        r_stat_conflicts <= r_stat_conflicts + STAT_W'(1);
      if (w_lock_own && (r_stat_lock_cycles != '1))
        r_stat_lock_cycles <= r_stat_lock_cycles + STAT_W'(1);
    end
  end

  assign o_stat_conflicts   = r_stat_conflicts;
  assign o_stat_lock_cycles = r_stat_lock_cycles;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_lock = 1'b0;
  logic [9:0]  mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic [15:0] env_mem [0:1023];
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_conf;
  logic [31:0] stat_lock;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter_if #(.p_WORD_LEN(16)) c_if ();
  mem_arbiter_if #(.p_WORD_LEN(16)) d_if ();

  mem_arbiter #(
    .p_WORD_LEN(16), .p_ADDR_LEN(10), .p_STARVE_LIMIT(STARVE)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .c_port(c_if), .d_port(d_if), .i_d_lock(d_lock),
    .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data)
`ifdef MEM_ARB_STATS_EN
    , .o_stat_conflicts(stat_conf), .o_stat_lock_cycles(stat_lock)
`endif
  );

  always #5 clk = ~clk;

  // Data memory with one-cycle read latency plus a backdoor load path.
  always @(posedge clk) begin
    if (bd_we) env_mem[bd_addr] <= bd_data;
    else if (mem_wr_en) env_mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= env_mem[mem_addr];
  end

  // Reference model state.
  logic [15:0] ref_mem [0:1023];
  bit          m_lock;
  int          m_wait;
  bit          exp_c_gnt, exp_d_gnt, exp_wr_en, exp_c_rv, exp_d_rv;
  logic [15:0] exp_c_rd, exp_d_rd;
  bit          cur_rst, cur_dr, cur_dl, g_any, g_dbg, g_we, g_in;
  logic [15:0] g_addr, g_wdata;

  task automatic drive(input bit r, input bit cr, input bit cw, input logic [15:0] ca,
                       input logic [15:0] cd, input bit dr, input bit dw,
                       input logic [15:0] da, input logic [15:0] dd, input bit dl);
    @(negedge clk);
    rst = r; d_lock = dl; bd_we = 1'b0;
    c_if.req = cr; c_if.we = cw; c_if.addr = ca; c_if.wdata = cd;
    d_if.req = dr; d_if.we = dw; d_if.addr = da; d_if.wdata = dd;
    cur_rst = r; cur_dr = dr; cur_dl = dl;
    #2;
    exp_c_gnt = 0; exp_d_gnt = 0;
    if (!r) begin
      if (m_lock && dl) exp_d_gnt = dr;
      else if (cr && dr) begin
        if (m_wait >= STARVE) exp_d_gnt = 1; else exp_c_gnt = 1;
      end else begin
        exp_c_gnt = cr; exp_d_gnt = dr;
      end
    end else begin
      exp_c_rv = 0; exp_d_rv = 0;
    end
    g_dbg = exp_d_gnt;
    g_any = exp_c_gnt || exp_d_gnt;
    g_addr  = g_dbg ? da : ca;
    g_we    = g_dbg ? dw : cw;
    g_wdata = g_dbg ? dd : cd;
    g_in    = (g_addr < 16'h0400);
    exp_wr_en = g_any && g_we && g_in;
  endtask

  task automatic commit();
    exp_c_rv = 0; exp_d_rv = 0;
    if (!cur_rst && g_any && !g_we) begin
      if (g_dbg) begin exp_d_rv = 1; exp_d_rd = g_in ? ref_mem[g_addr[9:0]] : 16'h0; end
      else       begin exp_c_rv = 1; exp_c_rd = g_in ? ref_mem[g_addr[9:0]] : 16'h0; end
    end
    if (exp_wr_en) ref_mem[g_addr[9:0]] = g_wdata;
    if (cur_rst || exp_d_gnt || !cur_dr) m_wait = 0;
    else if (exp_c_gnt && m_wait < STARVE) m_wait = m_wait + 1;
    if (cur_rst) m_lock = 0;
    else if (m_lock) m_lock = cur_dl;
    else m_lock = exp_d_gnt && cur_dl;
    @(posedge clk);
  endtask

  task automatic load_word(input logic [9:0] a, input logic [15:0] d);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
    commit();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 16'h0021, 16'h0, 1, 1, 16'h0022, 16'h1234, 1);
      n_tests++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin n_fail++;
        $display("FAIL reset_gnt: c=%b d=%b want 0/0", c_if.gnt, d_if.gnt); end
      n_tests++; if (mem_wr_en !== 1'b0) begin n_fail++;
        $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
      n_tests++; if (c_if.rvalid !== 1'b0 || d_if.rvalid !== 1'b0) begin n_fail++;
        $display("FAIL reset_rvalid: c=%b d=%b want 0/0", c_if.rvalid, d_if.rvalid); end
      n_tests++; if (c_if.rdata !== 16'h0 || d_if.rdata !== 16'h0) begin n_fail++;
        $display("FAIL reset_rdata: c=%h d=%h want 0/0", c_if.rdata, d_if.rdata); end
      commit();
    end
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    commit();
  endtask

  task automatic test_core_read();
    load_word(10'h021, 16'hBEEF);
    drive(0, 1, 0, 16'h0021, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin n_fail++;
      $display("FAIL core_read_gnt: c=%b d=%b want 1/0", c_if.gnt, d_if.gnt); end
    n_tests++; if (mem_addr !== 10'h021 || mem_wr_en !== 1'b0) begin n_fail++;
      $display("FAIL core_read_mem: addr=%h we=%b want 021/0", mem_addr, mem_wr_en); end
    commit();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (c_if.rvalid !== 1'b1 || c_if.rdata !== 16'hBEEF) begin n_fail++;
      $display("FAIL core_read_ret: rv=%b data=%h want 1/beef", c_if.rvalid, c_if.rdata); end
    n_tests++; if (d_if.rvalid !== 1'b0) begin n_fail++;
      $display("FAIL core_read_dbg_rv: got %b want 0", d_if.rvalid); end
    commit();
  endtask

  task automatic test_starvation();
    bit want_d;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 16'($urandom % 1024), 16'h0, 1, 0, 16'($urandom % 1024), 16'h0, 0);
      want_d = (i % 5 == 4) && (i < 15);
      if (i < 15) begin
        n_tests++; if (d_if.gnt !== want_d || c_if.gnt !== !want_d) begin n_fail++;
          $display("FAIL starve_pattern[%0d]: c=%b d=%b want %b/%b", i, c_if.gnt, d_if.gnt, !want_d, want_d); end
      end
      if (i > 0) begin
        n_tests++; if (c_if.rvalid !== exp_c_rv || d_if.rvalid !== exp_d_rv) begin n_fail++;
          $display("FAIL starve_rvalid[%0d]: c=%b d=%b want %b/%b", i, c_if.rvalid, d_if.rvalid, exp_c_rv, exp_d_rv); end
        n_tests++; if ((exp_c_rv && c_if.rdata !== exp_c_rd) || (exp_d_rv && d_if.rdata !== exp_d_rd)) begin n_fail++;
          $display("FAIL starve_rdata[%0d]: c=%h d=%h want %h/%h", i, c_if.rdata, d_if.rdata, exp_c_rd, exp_d_rd); end
      end
      if (i == 15) drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      commit();
    end
  endtask

  task automatic test_out_of_range();
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0400, 16'h5A5A, 0);
    n_tests++; if (d_if.gnt !== 1'b1 || mem_wr_en !== 1'b0) begin n_fail++;
      $display("FAIL oor_write: gnt=%b we=%b want 1/0", d_if.gnt, mem_wr_en); end
    commit();
    drive(0, 1, 1, 16'h8021, 16'h1111, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (c_if.gnt !== 1'b1 || mem_wr_en !== 1'b0) begin n_fail++;
      $display("FAIL oor_core_write: gnt=%b we=%b want 1/0", c_if.gnt, mem_wr_en); end
    commit();
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0400, 16'h0, 0);
    commit();
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0000, 16'h0, 0);
    n_tests++; if (d_if.rvalid !== 1'b1 || d_if.rdata !== 16'h0) begin n_fail++;
      $display("FAIL oor_read: rv=%b data=%h want 1/0", d_if.rvalid, d_if.rdata); end
    commit();
    drive(0, 1, 0, 16'h0021, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (d_if.rvalid !== 1'b1 || d_if.rdata !== exp_d_rd) begin n_fail++;
      $display("FAIL oor_alias0: rv=%b data=%h want 1/%h", d_if.rvalid, d_if.rdata, exp_d_rd); end
    commit();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (c_if.rvalid !== 1'b1 || c_if.rdata !== 16'hBEEF) begin n_fail++;
      $display("FAIL oor_alias21: rv=%b data=%h want 1/beef", c_if.rvalid, c_if.rdata); end
    commit();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 16'h0010, 16'h0, 1, 1, 16'h0100, 16'hA000, 1);
      n_tests++; if (d_if.gnt !== (i == 4) || c_if.gnt !== (i != 4)) begin n_fail++;
        $display("FAIL lock_entry[%0d]: c=%b d=%b want %b/%b", i, c_if.gnt, d_if.gnt, i != 4, i == 4); end
      commit();
    end
    for (int k = 1; k < 3; k++) begin
      drive(0, 1, 0, 16'h0010, 16'h0, 1, 1, 16'(16'h0100 + k), 16'(16'hA000 + k), 1);
      n_tests++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b1) begin n_fail++;
        $display("FAIL lock_burst[%0d]: c=%b d=%b want 0/1", k, c_if.gnt, d_if.gnt); end
      n_tests++; if (mem_wr_en !== 1'b1 || mem_addr !== 10'(10'h100 + k)) begin n_fail++;
        $display("FAIL lock_write[%0d]: we=%b addr=%h want 1/%h", k, mem_wr_en, mem_addr, 10'h100 + k); end
      commit();
    end
    drive(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    n_tests++; if (c_if.gnt !== 1'b0 || d_if.gnt !== 1'b0) begin n_fail++;
      $display("FAIL lock_idle: c=%b d=%b want 0/0", c_if.gnt, d_if.gnt); end
    commit();
    drive(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (c_if.gnt !== 1'b1) begin n_fail++;
      $display("FAIL lock_release: c=%b want 1", c_if.gnt); end
    commit();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'(16'h0100 + k), 16'h0, 0);
      else       drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
      if (k > 0) begin
        n_tests++; if (d_if.rvalid !== 1'b1 || d_if.rdata !== 16'(16'hA000 + k - 1)) begin n_fail++;
          $display("FAIL lock_readback[%0d]: rv=%b data=%h want 1/%h", k - 1, d_if.rvalid, d_if.rdata, 16'hA000 + k - 1); end
      end
      commit();
    end
  endtask

  task automatic test_rst_mid_read();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 16'(16'h0030 + i), 16'h0, 1, 0, 16'h0040, 16'h0, 0);
      n_tests++; if (c_if.gnt !== 1'b1) begin n_fail++;
        $display("FAIL rmr_pre[%0d]: c=%b want 1", i, c_if.gnt); end
      commit();
    end
    drive(1, 1, 0, 16'h0030, 16'h0, 1, 0, 16'h0040, 16'h0, 0);
    n_tests++; if (c_if.rvalid !== 1'b0) begin n_fail++;
      $display("FAIL rmr_rvalid_in_rst: got %b want 0", c_if.rvalid); end
    commit();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 16'h0031, 16'h0, 1, 0, 16'h0041, 16'h0, 1);
      if (i == 0) begin
        n_tests++; if (c_if.rvalid !== 1'b0) begin n_fail++;
          $display("FAIL rmr_rvalid_after: got %b want 0", c_if.rvalid); end
      end
      n_tests++; if (d_if.gnt !== (i == 4) || c_if.gnt !== (i != 4)) begin n_fail++;
        $display("FAIL rmr_counter[%0d]: c=%b d=%b want %b/%b", i, c_if.gnt, d_if.gnt, i != 4, i == 4); end
      commit();
    end
    drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0041, 16'h0, 1);
    commit();
    drive(0, 1, 0, 16'h0031, 16'h0, 1, 0, 16'h0041, 16'h0, 1);
    n_tests++; if (c_if.gnt !== 1'b1 || d_if.gnt !== 1'b0) begin n_fail++;
      $display("FAIL rmr_fsm_arb: c=%b d=%b want 1/0", c_if.gnt, d_if.gnt); end
    commit();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    commit();
  endtask

  task automatic test_random();
    int          hold = 0;
    bit          r, cr, cw, dr, dw, dl;
    logic [15:0] ca, da;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom % 100) == 0;
      cr = ($urandom % 4) != 0;
      cw = ($urandom % 2) == 0;
      dr = ($urandom % 3) == 0;
      dw = ($urandom % 2) == 0;
      ca = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom % 1024);
      da = (($urandom % 8) == 0) ? 16'($urandom) : 16'($urandom % 1024);
      if (hold == 0 && ($urandom % 15) == 0) hold = 1 + int'($urandom % 6);
      dl = hold > 0;
      if (hold > 0) begin hold--; dr = ($urandom % 4) != 0; end
      drive(r, cr, cw, ca, 16'($urandom), dr, dw, da, 16'($urandom), dl);
      n_tests++; if (c_if.gnt !== exp_c_gnt || d_if.gnt !== exp_d_gnt) begin n_fail++;
        $display("FAIL rand_gnt[%0d]: c=%b d=%b want %b/%b", i, c_if.gnt, d_if.gnt, exp_c_gnt, exp_d_gnt); end
      n_tests++; if (mem_wr_en !== exp_wr_en) begin n_fail++;
        $display("FAIL rand_wr_en[%0d]: got %b want %b", i, mem_wr_en, exp_wr_en); end
      if (g_any && g_in) begin
        n_tests++; if (mem_addr !== g_addr[9:0] || (g_we && mem_wr_data !== g_wdata)) begin n_fail++;
          $display("FAIL rand_mem_bus[%0d]: addr=%h data=%h want %h/%h", i, mem_addr, mem_wr_data, g_addr[9:0], g_wdata); end
      end
      n_tests++; if (c_if.rvalid !== exp_c_rv || d_if.rvalid !== exp_d_rv) begin n_fail++;
        $display("FAIL rand_rvalid[%0d]: c=%b d=%b want %b/%b", i, c_if.rvalid, d_if.rvalid, exp_c_rv, exp_d_rv); end
      if (exp_c_rv || exp_d_rv) begin
        n_tests++; if ((exp_c_rv && c_if.rdata !== exp_c_rd) || (exp_d_rv && d_if.rdata !== exp_d_rd)) begin n_fail++;
          $display("FAIL rand_rdata[%0d]: c=%h d=%h want %h/%h", i, c_if.rdata, d_if.rdata, exp_c_rd, exp_d_rd); end
      end
      commit();
    end
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    commit();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    commit();
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 16'h0005, 16'h0, 1, 0, 16'h0006, 16'h0, 0);
      commit();
    end
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    n_tests++; if (stat_conf !== 32'd10) begin n_fail++;
      $display("FAIL stats_conflicts: got %0d want 10", stat_conf); end
    n_tests++; if (stat_lock !== 32'd0) begin n_fail++;
      $display("FAIL stats_lock_cycles: got %0d want 0", stat_lock); end
    commit();
  endtask
`endif

  initial begin
    logic [15:0] v;
    c_if.req = 0; c_if.we = 0; c_if.addr = '0; c_if.wdata = '0;
    d_if.req = 0; d_if.we = 0; d_if.addr = '0; d_if.wdata = '0;
    m_lock = 0; m_wait = 0; exp_c_rv = 0; exp_d_rv = 0;
    exp_c_rd = '0; exp_d_rd = '0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      v = 16'($urandom);
      bd_we = 1'b1; bd_addr = 10'(i); bd_data = v; ref_mem[i] = v;
    end
    @(negedge clk);
    bd_we = 1'b0;
    @(posedge clk);
    test_reset();
    test_core_read();
    test_starvation();
    test_out_of_range();
    test_lock();
    test_rst_mid_read();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
